mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous memory (1-cycle read latency) between `NUM_REQ` requesters. It accepts at most one read or write per cycle, drives registered memory controls, and returns a tagged response for every accepted request. It sits between the requester-side agents of the `mem` interface package and the memory model or SRAM macro.

---
 rtl/mem_pkg_hdl.sv | 19 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_rr_picker.sv | 40 ++++
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg_hdl.sv
// Shared widths and transaction types for the round-robin memory arbiter.
package mem_pkg_hdl;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } mem_arb_op_t;

    typedef struct packed {
        logic                      we;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] rdata;
    } mem_arb_rsp_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and response signals of the arbiter; slave = arbiter view,
// master = environment view (requesters, memory macro and response sink).
interface mem_arbiter_if
    import mem_pkg_hdl::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;
    logic                          rsp_valid;
    logic                          rsp_we;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_we, rsp_id, rsp_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_we, rsp_id, rsp_rdata
    );
endinterface

// File: rtl/mem_rr_picker.sv
// Combinational grant selection: lowest-index masked (strict priority) requester
// first, otherwise first unmasked valid requester at or after rr_ptr with wrap.
module mem_rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    input  logic [NUM_REQ-1:0]  prio_mask,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);
    logic hit;
    int   j;

    always_comb begin
        hit       = 1'b0;
        grant_idx = '0;
        j         = 0;
        // descending scans so the last match written is the highest-priority one
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && prio_mask[i]) begin
                hit       = 1'b1;
                grant_idx = ID_WIDTH'(i);
            end
        end
        if (!hit) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (req_valid[j] && !prio_mask[j]) begin
                    hit       = 1'b1;
                    grant_idx = ID_WIDTH'(j);
                end
            end
        end
        grant = '0;
        if (hit) grant[grant_idx] = 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for a 1-cycle-latency single-port memory, 3-stage response pipe.
// Define MEM_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin.
module mem_arbiter
    import mem_pkg_hdl::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
`ifdef MEM_ARB_PRIO0_EN
    localparam logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1);
`else
    localparam logic [NUM_REQ-1:0] PRIO_MASK = '0;
`endif

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  handshake;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ID_WIDTH-1:0]   a_id;
    logic                  b_valid;
    logic                  b_we;
    logic [ID_WIDTH-1:0]   b_id;

    mem_rr_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .prio_mask (PRIO_MASK),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // ready is masked during reset so nothing looks accepted while flops are cleared
    assign bus.req_ready = rst ? grant : '0;
    assign handshake     = |grant;
    assign sel_we        = bus.req_we[grant_idx];
    assign sel_addr      = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata     = bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr        <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            a_id          <= '0;
            b_valid       <= 1'b0;
            b_we          <= 1'b0;
            b_id          <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            if (handshake && !PRIO_MASK[grant_idx])
                rr_ptr <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

            bus.mem_en <= handshake;
            bus.mem_we <= handshake & sel_we;
            if (handshake) begin
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                a_id          <= grant_idx;
            end

            b_valid <= bus.mem_en;
            b_we    <= bus.mem_we;
            b_id    <= a_id;

            bus.rsp_valid <= b_valid;
            bus.rsp_we    <= b_valid & b_we;
            bus.rsp_id    <= b_valid ? b_id : '0;
            bus.rsp_rdata <= (b_valid && !b_we) ? bus.mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard and a behavioural memory.
module tb_mem_arbiter;
    import mem_pkg_hdl::*;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        mem_arb_rsp_t rsp;
        logic [31:0]  due;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [DW-1:0] mem_data [0:255];
    logic [255:0]  mem_written = '0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h10) ? 16'hBEEF : {8'hA0, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_data[bus.mem_addr]    <= bus.mem_wdata;
                mem_written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= mem_written[bus.mem_addr] ? mem_data[bus.mem_addr]
                                                           : init_val(bus.mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_we",      32'(bus.rsp_we),    32'(mon_e.rsp.we));
                    check("rsp_id",      32'(bus.rsp_id),    32'(mon_e.rsp.id));
                    check("rsp_rdata",   32'(bus.rsp_rdata), 32'(mon_e.rsp.rdata));
                    check("rsp_cycle",   32'(cyc),           mon_e.due);
                end
            end else if (sb.size() != 0 && cyc >= int'(sb[0].due)) begin
                mon_e = sb.pop_front();
                check("rsp_missing", 32'(bus.rsp_valid), 32'd1);
            end
        end
    end

    task automatic drive(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic step_grant(input int id, input logic we, input logic [DW-1:0] rd);
        exp_t e;
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(1) << id);
        e.rsp.we    = we;
        e.rsp.id    = IW'(id);
        e.rsp.rdata = rd;
        e.due       = 32'(cyc + 3);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step_idle();
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",    32'(bus.mem_en),    32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        step_idle();

        // single read from requester 2
        drive(2, 1'b1, 1'b0, 8'h10, 16'h0);
        step_grant(2, 1'b0, 16'hBEEF);
        check("rd_mem_en",   32'(bus.mem_en),   32'd1);
        check("rd_mem_we",   32'(bus.mem_we),   32'd0);
        check("rd_mem_addr", 32'(bus.mem_addr), 32'h10);
        drive(2, 1'b0, 1'b0, 8'h0, 16'h0);
        repeat (4) step_idle();

        // write from 1 then read-back from 3, back to back
        drive(1, 1'b1, 1'b1, 8'h05, 16'h1234);
        step_grant(1, 1'b1, 16'h0);
        check("wr_mem_we",    32'(bus.mem_we),    32'd1);
        check("wr_mem_addr",  32'(bus.mem_addr),  32'h05);
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        drive(1, 1'b0, 1'b0, 8'h0, 16'h0);
        drive(3, 1'b1, 1'b0, 8'h05, 16'h0);
        step_grant(3, 1'b0, 16'h1234);
        drive(3, 1'b0, 1'b0, 8'h0, 16'h0);
        repeat (4) step_idle();

`ifndef MEM_ARB_PRIO0_EN
        // fairness: all four held valid for eight cycles
        for (int i = 0; i < NR; i++) drive(i, 1'b1, 1'b0, 8'(8'h20 + i), 16'h0);
        for (int k = 0; k < 8; k++) begin
            step_grant(k % NR, 1'b0, 16'(16'hA020 + (k % NR)));
            check("fair_mem_en", 32'(bus.mem_en), 32'd1);
        end
        for (int i = 0; i < NR; i++) drive(i, 1'b0, 1'b0, 8'h0, 16'h0);
        repeat (4) step_idle();

        // wrap: move rr_ptr to 3, then only 3 and 0 valid
        drive(2, 1'b1, 1'b0, 8'h22, 16'h0);
        step_grant(2, 1'b0, 16'hA022);
        drive(2, 1'b0, 1'b0, 8'h0, 16'h0);
        drive(3, 1'b1, 1'b0, 8'h23, 16'h0);
        drive(0, 1'b1, 1'b0, 8'h20, 16'h0);
        step_grant(3, 1'b0, 16'hA023);
        step_grant(0, 1'b0, 16'hA020);
        step_grant(3, 1'b0, 16'hA023);
        drive(3, 1'b0, 1'b0, 8'h0, 16'h0);
        drive(0, 1'b0, 1'b0, 8'h0, 16'h0);
        repeat (4) step_idle();
`else
        // strict priority: requester 0 beats 2 until it drops
        drive(0, 1'b1, 1'b0, 8'h20, 16'h0);
        drive(2, 1'b1, 1'b0, 8'h22, 16'h0);
        repeat (4) step_grant(0, 1'b0, 16'hA020);
        drive(0, 1'b0, 1'b0, 8'h0, 16'h0);
        step_grant(2, 1'b0, 16'hA022);
        drive(2, 1'b0, 1'b0, 8'h0, 16'h0);
        repeat (4) step_idle();
`endif

        // reset in the middle of a read, requester 2 still valid
        drive(2, 1'b1, 1'b0, 8'h10, 16'h0);
        step_grant(2, 1'b0, 16'hBEEF);
        check("mid_mem_en", 32'(bus.mem_en), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_mem_en",    32'(bus.mem_en),    32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(2, 1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) step_idle();
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
